toaster_ctrl: RTL and testbench
===============================

# toaster_ctrl

Parametrised multi-slot toaster controller; successor to the single 2-bit toaster state machine. Runs N_SLOTS independent IDLE/WARMUP/TOAST/COOL_DOWN sequencers, each with cycle-accurate programmable durations and a per-slot toast time. A shared heater budget caps how many slots heat at once. Per-slot state is held in a packed internal array, `state_int`, so benches can probe it hierarchically.

## Interface
- N_SLOTS, 2: number of independent slots (1..8).
- CNT_W, 8: width of duration counters and toast-time fields.
- WARMUP_CYC, 4: WARMUP duration in cycles (1..2^CNT_W-1).
- COOL_CYC, 3: COOL_DOWN duration in cycles (1..2^CNT_W-1).
- MAX_HEAT, 1: maximum slots simultaneously in WARMUP or TOAST (1..N_SLOTS).

- iClk  in  1  clock, rising edge.
- inRst  in  1  reset, asynchronous, active-low.
- iStart  in  N_SLOTS  per-slot start request, level-sampled.
- iToastTime  in  N_SLOTS*CNT_W  per-slot TOAST duration in cycles; slot i uses bits [i*CNT_W +: CNT_W].
- iAbort  in  N_SLOTS  per-slot abort; present only with TOASTER_ABORT_EN.
- oState  out  N_SLOTS*2  per-slot state encoding, equal to `state_int`.
- oBusy  out  N_SLOTS  slot is pending or not IDLE.
- oHeat  out  N_SLOTS  slot is in WARMUP or TOAST.
- oDone  out  N_SLOTS  one-cycle pulse on completion of a full sequence.

## Operation
- State encoding: IDLE=00, WARMUP=01, TOAST=10, COOL_DOWN=11.
- Reset: all slots IDLE; counters, pending bits and oDone cleared; all outputs 0.
- Start in IDLE with iToastTime=0: ignored; no pending bit set, no oDone.
- Start in IDLE with non-zero time: capture the slot's toast time and set its pending bit.
- iStart while a slot is pending or not IDLE: ignored; no queueing, no recapture.
- Budget: heat_cnt is the count of slots whose registered state is WARMUP or TOAST.
  - Grants available this cycle = MAX_HEAT - heat_cnt.
  - Pending slots are granted in lowest-index-first order, up to the available grants.
  - A pending slot may be granted in the same cycle its start is sampled.
- Granted slot: IDLE→WARMUP. The pending bit clears and the counter loads WARMUP_CYC-1.
- Counter: decrements each cycle. At 0, the slot moves to the next state:
  - WARMUP→TOAST, counter loads captured time-1.
  - TOAST→COOL_DOWN, counter loads COOL_CYC-1.
  - COOL_DOWN→IDLE.
- A slot leaving TOAST still counts toward heat_cnt in that cycle. Its budget is released on the following cycle.
- oDone: registered pulse, high for exactly the first IDLE cycle after COOL_DOWN.

## Timing
- Each state lasts exactly its programmed cycle count.
- Start sampled at the end of cycle 0 with budget free:
  - WARMUP for cycles 1..W.
  - TOAST for W+1..W+T.
  - COOL_DOWN for W+T+1..W+T+C.
  - oDone high in cycle W+T+C+1.
- All outputs are registered or decoded from registered state only.
- No combinational path from any input to any output.
- Async reset mid-sequence: immediate return to IDLE; oDone is not asserted.

## Configuration
- Macro: TOASTER_ABORT_EN.
- Defined:
  - iAbort exists. Abort in WARMUP or TOAST forces COOL_DOWN next cycle, with counter COOL_CYC-1.
  - Abort on a pending slot clears the pending bit.
  - Abort in IDLE or COOL_DOWN is ignored.
  - A sequence that was aborted ends without an oDone pulse; a per-slot aborted flag tracks this.
  - Abort has priority over a same-cycle grant or counter transition.
- Undefined: no iAbort port and no abort logic; every granted sequence completes and pulses oDone.

## Structure
- Package toaster_pkg: state_type enum with the encodings above, and width constant STATE_W=2.
- Sub-module toaster_slot: one slot's FSM, counter, captured time, pending/aborted flags and oDone register. It takes a grant input and reports heating and pending status.
- toaster_ctrl instantiates N_SLOTS toaster_slot instances. It owns the heat_cnt popcount, the priority grant logic and the `state_int` array.

## Test plan
- Defaults, slot0 start, time=5 at cycle 0 → WARMUP 1-4, TOAST 5-9, COOL_DOWN 10-12, oDone[0]=1 only in cycle 13.
- MAX_HEAT=1, both slots start same cycle, time=2 → slot0 granted at cycle 1; slot1 oBusy=1 but IDLE until cycle 8, then WARMUP.
- N_SLOTS=4, MAX_HEAT=2, all start together → slots 0,1 heat first; oHeat popcount never exceeds 2.
- Start with time=0 → oBusy stays 0, state stays IDLE, no oDone; start during TOAST → ignored, time unchanged.
- TOASTER_ABORT_EN, abort slot0 in TOAST cycle 6 → COOL_DOWN 7-9, IDLE at 10, oDone never pulses.
- inRst low during TOAST → all outputs 0 immediately; after release, slot idles until a new start.

Source files
------------

// File: rtl/toaster_pkg.sv
// Shared types for the multi-slot toaster controller.
package toaster_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'b00,
    WARMUP    = 2'b01,
    TOAST     = 2'b10,
    COOL_DOWN = 2'b11
  } state_type;

endpackage

// File: rtl/toaster_slot.sv
// One toaster slot: sequencer FSM, duration counter, captured toast time, pending/done flags.
// Optional abort support is compiled in with TOASTER_ABORT_EN.
module toaster_slot
  import toaster_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int WARMUP_CYC = 4,
  parameter int COOL_CYC   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] toast_time,
  input  logic             grant,
`ifdef TOASTER_ABORT_EN
  input  logic             abort,
`endif
  output state_type        state,
  output logic             req,
  output logic             heat,
  output logic             pending,
  output logic             done
);

  localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOL_CYC - 1);

  state_type        state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, time_q;
  logic             pending_q, done_q, aborted;
  logic             start_ok, cnt_zero, abort_hit;

`ifdef TOASTER_ABORT_EN
  logic aborted_q;

  assign abort_hit = abort;
  assign aborted   = aborted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted_q <= 1'b0;
    end else if (abort_hit && (state_q == WARMUP || state_q == TOAST)) begin
      aborted_q <= 1'b1;
    end else if (state_q == COOL_DOWN && state_nx == IDLE) begin
      aborted_q <= 1'b0;
    end
  end
`else
  assign abort_hit = 1'b0;
  assign aborted   = 1'b0;
`endif

  assign start_ok = start && (state_q == IDLE) && !pending_q && (toast_time != '0);
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      IDLE:      if (grant)    state_nx = WARMUP;
      WARMUP:    if (cnt_zero) state_nx = TOAST;
      TOAST:     if (cnt_zero) state_nx = COOL_DOWN;
      COOL_DOWN: if (cnt_zero) state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
    // Abort overrides any same-cycle counter expiry in a heating state.
    if (abort_hit && (state_q == WARMUP || state_q == TOAST)) state_nx = COOL_DOWN;
  end

  always_comb begin
    heat = (state_q == WARMUP) || (state_q == TOAST);
    req  = (pending_q || start_ok) && !abort_hit;
  end

  // Counter reloads on every state change, otherwise counts down while active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      time_q    <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (state_nx != state_q) begin
        unique case (state_nx)
          WARMUP:    cnt_q <= WARM_LOAD;
          TOAST:     cnt_q <= time_q - CNT_W'(1);
          COOL_DOWN: cnt_q <= COOL_LOAD;
          default:   cnt_q <= '0;
        endcase
      end else if (state_q != IDLE) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (start_ok) time_q <= toast_time;
      pending_q <= req && !grant;
      done_q    <= (state_q == COOL_DOWN) && (state_nx == IDLE) && !aborted;
    end
  end

  assign state   = state_q;
  assign pending = pending_q;
  assign done    = done_q;

endmodule

// File: rtl/toaster_ctrl.sv
// Multi-slot toaster controller: N_SLOTS sequencers sharing a heater budget of MAX_HEAT.
// Optional per-slot abort is compiled in with TOASTER_ABORT_EN.
module toaster_ctrl
  import toaster_pkg::*;
#(
  parameter int N_SLOTS    = 2,
  parameter int CNT_W      = 8,
  parameter int WARMUP_CYC = 4,
  parameter int COOL_CYC   = 3,
  parameter int MAX_HEAT   = 1
) (
  input  logic                       iClk,
  input  logic                       inRst,
  input  logic [N_SLOTS-1:0]         iStart,
  input  logic [N_SLOTS*CNT_W-1:0]   iToastTime,
`ifdef TOASTER_ABORT_EN
  input  logic [N_SLOTS-1:0]         iAbort,
`endif
  output logic [N_SLOTS*STATE_W-1:0] oState,
  output logic [N_SLOTS-1:0]         oBusy,
  output logic [N_SLOTS-1:0]         oHeat,
  output logic [N_SLOTS-1:0]         oDone
);

  localparam int              CW         = $clog2(N_SLOTS + 1);
  localparam logic [CW-1:0]   MAX_HEAT_C = CW'(MAX_HEAT);

  logic [N_SLOTS-1:0][STATE_W-1:0] state_int;
  logic [N_SLOTS-1:0]              req, heat, pending, done, grant;
  logic [CW-1:0]                   heat_cnt, avail, used;

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    toaster_slot #(
      .CNT_W      (CNT_W),
      .WARMUP_CYC (WARMUP_CYC),
      .COOL_CYC   (COOL_CYC)
    ) u_slot (
      .clk        (iClk),
      .rst_n      (inRst),
      .start      (iStart[i]),
      .toast_time (iToastTime[i*CNT_W +: CNT_W]),
      .grant      (grant[i]),
`ifdef TOASTER_ABORT_EN
      .abort      (iAbort[i]),
`endif
      .state      (state_int[i]),
      .req        (req[i]),
      .heat       (heat[i]),
      .pending    (pending[i]),
      .done       (done[i])
    );
  end

  // Budget is taken from registered state, so a slot leaving TOAST frees it one cycle later.
  always_comb begin
    heat_cnt = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) heat_cnt = heat_cnt + CW'(heat[i]);
  end

  always_comb begin
    avail = MAX_HEAT_C - heat_cnt;
    used  = '0;
    grant = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (req[i] && (used < avail)) begin
        grant[i] = 1'b1;
        used     = used + CW'(1);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_SLOTS; i++) oBusy[i] = pending[i] || (state_int[i] != IDLE);
  end

  assign oState = state_int;
  assign oHeat  = heat;
  assign oDone  = done;

endmodule

// File: tb/tb_toaster_ctrl.sv
// Scoreboard bench for toaster_ctrl: stimulus queues per-cycle expected outputs, a monitor compares.
module tb_toaster_ctrl;

  logic        iClk = 1'b0;
  logic        inRst;
  logic [1:0]  start2, abort2, busy2, heat2, done2;
  logic [15:0] time2;
  logic [3:0]  state2;
  logic [3:0]  start4, abort4, busy4, heat4, done4;
  logic [31:0] time4;
  logic [7:0]  state4;

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  toaster_ctrl u_dut (
    .iClk       (iClk),
    .inRst      (inRst),
    .iStart     (start2),
    .iToastTime (time2),
`ifdef TOASTER_ABORT_EN
    .iAbort     (abort2),
`endif
    .oState     (state2),
    .oBusy      (busy2),
    .oHeat      (heat2),
    .oDone      (done2)
  );

  toaster_ctrl #(.N_SLOTS(4), .MAX_HEAT(2)) u_dut4 (
    .iClk       (iClk),
    .inRst      (inRst),
    .iStart     (start4),
    .iToastTime (time4),
`ifdef TOASTER_ABORT_EN
    .iAbort     (abort4),
`endif
    .oState     (state4),
    .oBusy      (busy4),
    .oHeat      (heat4),
    .oDone      (done4)
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic [19:0] expv;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   hchk   = 1'b0;

  // Expected {state, busy, heat, done} of one slot, k cycles after its start was sampled.
  // s = first WARMUP cycle (0 = slot unused), x = toast time; WARMUP=4, COOL=3.
  function automatic logic [4:0] slot_exp(input int k, input int s, input int x);
    logic [1:0] st;
    logic       bu, he, dn;
    if (s == 0) return 5'b0;
    if (k >= s && k <= s + 3)                 st = 2'b01;
    else if (k >= s + 4 && k <= s + 3 + x)    st = 2'b10;
    else if (k >= s + 4 + x && k <= s + 6 + x) st = 2'b11;
    else                                      st = 2'b00;
    bu = (k >= 1) && (k <= s + 6 + x);
    he = (st == 2'b01) || (st == 2'b10);
    dn = (k == s + 7 + x);
    return {st, bu, he, dn};
  endfunction

  task automatic push_exp(input int sel, input int t0, input int k_lo, input int k_hi,
                          input int s0, input int x0, input int s1, input int x1,
                          input int s2, input int x2, input int s3, input int x3,
                          input string name);
    int ss[4];
    int xx[4];
    logic [7:0] st;
    logic [3:0] bu, he, dn;
    logic [4:0] v;
    exp_t e;
    ss = '{s0, s1, s2, s3};
    xx = '{x0, x1, x2, x3};
    for (int k = k_lo; k <= k_hi; k++) begin
      for (int j = 0; j < 4; j++) begin
        v = slot_exp(k, ss[j], xx[j]);
        st[j*2 +: 2] = v[4:3];
        bu[j] = v[2];
        he[j] = v[1];
        dn[j] = v[0];
      end
      e.cyc  = t0 + k;
      e.sel  = sel;
      e.name = name;
      if (sel == 0) e.expv = {10'b0, st[3:0], bu[1:0], he[1:0], dn[1:0]};
      else          e.expv = {st, bu, he, dn};
      q.push_back(e);
    end
  endtask

  task automatic push_raw(input int c, input int sel, input logic [19:0] v, input string name);
    exp_t e;
    e.cyc  = c;
    e.sel  = sel;
    e.expv = v;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      @(posedge iClk);
      n++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d expected entries left, required 0", name, q.size());
      q.delete();
    end
    @(posedge iClk);
    #1;
  endtask

  always @(negedge iClk) begin : monitor
    exp_t        e;
    logic [19:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.sel == 0) act = {10'b0, state2, busy2, heat2, done2};
      else            act = {state4, busy4, heat4, done4};
      if (e.cyc != cyc || act !== e.expv) begin
        errors++;
        $display("FAIL %s cyc=%0d: got %h (state,busy,heat,done) required %h at cyc %0d",
                 e.name, cyc, act, e.expv, e.cyc);
      end
    end
    if (hchk) begin
      checks++;
      if ($countones(heat4) > 2) begin
        errors++;
        $display("FAIL heat_budget cyc=%0d: oHeat=%b popcount %0d, required <= 2",
                 cyc, heat4, $countones(heat4));
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    inRst  = 1'b0;
    start2 = '0;
    abort2 = '0;
    time2  = '0;
    start4 = '0;
    abort4 = '0;
    time4  = '0;

    repeat (3) @(posedge iClk);
    #1;
    push_raw(cyc, 0, 20'h0, "reset_dut");
    push_raw(cyc, 1, 20'h0, "reset_dut4");
    @(posedge iClk);
    #1;
    inRst = 1'b1;
    @(posedge iClk);
    #1;

    // Single slot, full sequence.
    t = cyc;
    push_exp(0, t, 1, 15, 1, 5, 0, 0, 0, 0, 0, 0, "single_seq");
    time2  = {8'd0, 8'd5};
    start2 = 2'b01;
    @(posedge iClk);
    #1;
    start2 = '0;
    drain("single_seq");

    // Both slots together, budget of one: slot1 waits until slot0 leaves TOAST.
    t = cyc;
    push_exp(0, t, 1, 18, 1, 2, 8, 2, 0, 0, 0, 0, "budget_wait");
    time2  = {8'd2, 8'd2};
    start2 = 2'b11;
    @(posedge iClk);
    #1;
    start2 = '0;
    drain("budget_wait");

    // Zero toast time is ignored.
    t = cyc;
    push_exp(0, t, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, "zero_time");
    time2  = {8'd0, 8'd0};
    start2 = 2'b01;
    @(posedge iClk);
    #1;
    start2 = '0;
    drain("zero_time");

    // Start during TOAST must not recapture the time.
    t = cyc;
    push_exp(0, t, 1, 13, 0, 0, 1, 3, 0, 0, 0, 0, "restart_ignored");
    time2  = {8'd3, 8'd0};
    start2 = 2'b10;
    @(posedge iClk);
    #1;
    start2 = '0;
    goto(t + 6);
    time2  = {8'd9, 8'd0};
    start2 = 2'b10;
    @(posedge iClk);
    #1;
    start2 = '0;
    drain("restart_ignored");

    // Four slots, budget of two, plus a per-cycle budget check.
    hchk = 1'b1;
    t = cyc;
    push_exp(1, t, 1, 18, 1, 2, 1, 2, 8, 2, 8, 2, "four_slots");
    time4  = {8'd2, 8'd2, 8'd2, 8'd2};
    start4 = 4'hF;
    @(posedge iClk);
    #1;
    start4 = '0;
    drain("four_slots");
    hchk = 1'b0;

    // Asynchronous reset during TOAST.
    t = cyc;
    push_exp(0, t, 1, 5, 1, 5, 0, 0, 0, 0, 0, 0, "pre_reset");
    push_exp(0, t, 6, 14, 0, 0, 0, 0, 0, 0, 0, 0, "mid_reset");
    time2  = {8'd0, 8'd5};
    start2 = 2'b01;
    @(posedge iClk);
    #1;
    start2 = '0;
    goto(t + 6);
    inRst = 1'b0;
    goto(t + 8);
    inRst = 1'b1;
    drain("mid_reset");

`ifdef TOASTER_ABORT_EN
    // Abort in TOAST: straight to COOL_DOWN, no done pulse.
    t = cyc;
    for (int k = 1; k <= 13; k++) begin
      logic [1:0] st;
      if (k <= 4)      st = 2'b01;
      else if (k <= 6) st = 2'b10;
      else if (k <= 9) st = 2'b11;
      else             st = 2'b00;
      push_raw(t + k, 0, {10'b0, 2'b00, st, 1'b0, (k <= 9), 1'b0, (k <= 6), 2'b00}, "abort_toast");
    end
    time2  = {8'd0, 8'd5};
    start2 = 2'b01;
    @(posedge iClk);
    #1;
    start2 = '0;
    goto(t + 6);
    abort2 = 2'b01;
    @(posedge iClk);
    #1;
    abort2 = '0;
    drain("abort_toast");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
